// File: rtl/ip_ttl_checksum_rewrite.sv
// IPv4 TTL decrement with incremental header-checksum rewrite on a 256-bit AXI stream.
// Header beat is held for one fold cycle; payload beats pass straight through.
module ip_ttl_checksum_rewrite #(
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int BAD_BIT_POS          = 32
) (
   input  logic                              AXI_ACLK,
   input  logic                              AXI_RESET,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
   input  logic                              S_AXIS_TVALID,
   output logic                              S_AXIS_TREADY,
   input  logic                              S_AXIS_TLAST,
   input  logic [31:0]                       CHECKSUM_A,
   input  logic [31:0]                       CHECKSUM_B,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
   output logic                              M_AXIS_TVALID,
   input  logic                              M_AXIS_TREADY,
   output logic                              M_AXIS_TLAST,
   output logic [31:0]                       good_count,
   output logic [31:0]                       bad_csum_count,
   output logic [31:0]                       ttl_expired_count
);

   // state    | meaning
   // WAIT_HDR | ready for a header beat, output idle
   // FOLD     | fold partial sums, register rewritten header beat
   // EMIT     | present header beat until downstream accepts it
   // PASS     | payload beats flow through combinationally
   typedef enum logic [1:0] {WAIT_HDR, FOLD, EMIT, PASS} state_t;

   localparam logic [1:0] OUT_GOOD = 2'd0;
   localparam logic [1:0] OUT_BAD  = 2'd1;
   localparam logic [1:0] OUT_TTL  = 2'd2;

   state_t state_q, state_d;

   logic [C_M_AXIS_DATA_WIDTH-1:0]   data_q, data_d;
   logic [C_M_AXIS_DATA_WIDTH/8-1:0] strb_q, strb_d;
   logic [C_M_AXIS_TUSER_WIDTH-1:0]  user_q, user_d;
   logic                             last_q, last_d;
   logic [31:0]                      csum_a_q, csum_a_d;
   logic [31:0]                      csum_b_q, csum_b_d;
   logic [1:0]                       outcome_q, outcome_d;
   logic [31:0]                      good_q, good_d;
   logic [31:0]                      bad_q, bad_d;
   logic [31:0]                      ttl_exp_q, ttl_exp_d;

   logic [32:0] s33;
   logic [16:0] f1;
   logic [15:0] f;
   logic [16:0] hc_sum;
   logic [15:0] hc_new;
   logic        hdr_ok;
   logic        ttl_ok;

   assign s33    = {1'b0, csum_a_q} + {1'b0, csum_b_q};
   assign f1     = {1'b0, s33[15:0]} + {1'b0, s33[31:16]} + {16'b0, s33[32]};
   assign f      = f1[15:0] + {15'b0, f1[16]};
   assign hdr_ok = (data_q[159:144] == 16'h0800) && (data_q[143:136] == 8'h45) && (f == 16'hFFFF);
   assign ttl_ok = (data_q[79:72] > 8'd1);

   // Adding 0x0100 to the stored checksum compensates a TTL decrement of one.
   assign hc_sum = {1'b0, data_q[63:48]} + 17'h00100;
   assign hc_new = hc_sum[15:0] + {15'b0, hc_sum[16]};

   always_ff @(posedge AXI_ACLK) begin
      if (AXI_RESET) begin
         state_q   <= WAIT_HDR;
         data_q    <= '0;
         strb_q    <= '0;
         user_q    <= '0;
         last_q    <= 1'b0;
         csum_a_q  <= '0;
         csum_b_q  <= '0;
         outcome_q <= OUT_GOOD;
         good_q    <= '0;
         bad_q     <= '0;
         ttl_exp_q <= '0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         strb_q    <= strb_d;
         user_q    <= user_d;
         last_q    <= last_d;
         csum_a_q  <= csum_a_d;
         csum_b_q  <= csum_b_d;
         outcome_q <= outcome_d;
         good_q    <= good_d;
         bad_q     <= bad_d;
         ttl_exp_q <= ttl_exp_d;
      end
   end

   always_comb begin
      data_d    = data_q;
      strb_d    = strb_q;
      user_d    = user_q;
      last_d    = last_q;
      csum_a_d  = csum_a_q;
      csum_b_d  = csum_b_q;
      outcome_d = outcome_q;
      good_d    = good_q;
      bad_d     = bad_q;
      ttl_exp_d = ttl_exp_q;
      if (state_q == WAIT_HDR && S_AXIS_TVALID) begin
         data_d   = S_AXIS_TDATA;
         strb_d   = S_AXIS_TSTRB;
         user_d   = S_AXIS_TUSER;
         last_d   = S_AXIS_TLAST;
         csum_a_d = CHECKSUM_A;
         csum_b_d = CHECKSUM_B;
      end
      if (state_q == FOLD) begin
         if (hdr_ok && ttl_ok) begin
            data_d[79:72] = data_q[79:72] - 8'd1;
            data_d[63:48] = hc_new;
            outcome_d     = OUT_GOOD;
         end else begin
            user_d[BAD_BIT_POS] = 1'b1;
            outcome_d           = hdr_ok ? OUT_TTL : OUT_BAD;
         end
      end
      if (state_q == EMIT && M_AXIS_TREADY) begin
         case (outcome_q)
            OUT_GOOD: good_d    = good_q + 32'd1;
            OUT_BAD:  bad_d     = bad_q + 32'd1;
            default:  ttl_exp_d = ttl_exp_q + 32'd1;
         endcase
      end
   end

   always_comb begin
      state_d       = state_q;
      S_AXIS_TREADY = 1'b0;
      M_AXIS_TVALID = 1'b0;
      M_AXIS_TDATA  = data_q;
      M_AXIS_TSTRB  = strb_q;
      M_AXIS_TUSER  = user_q;
      M_AXIS_TLAST  = last_q;
      case (state_q)
         WAIT_HDR: begin
            S_AXIS_TREADY = 1'b1;
            if (S_AXIS_TVALID) state_d = FOLD;
         end
         FOLD: state_d = EMIT;
         EMIT: begin
            M_AXIS_TVALID = 1'b1;
            if (M_AXIS_TREADY) state_d = last_q ? WAIT_HDR : PASS;
         end
         PASS: begin
            M_AXIS_TVALID = S_AXIS_TVALID;
            M_AXIS_TDATA  = S_AXIS_TDATA;
            M_AXIS_TSTRB  = S_AXIS_TSTRB;
            M_AXIS_TUSER  = S_AXIS_TUSER;
            M_AXIS_TLAST  = S_AXIS_TLAST;
            S_AXIS_TREADY = M_AXIS_TREADY;
            if (S_AXIS_TVALID && M_AXIS_TREADY && S_AXIS_TLAST) state_d = WAIT_HDR;
         end
         default: state_d = WAIT_HDR;
      endcase
   end

   assign good_count        = good_q;
   assign bad_csum_count    = bad_q;
   assign ttl_expired_count = ttl_exp_q;

endmodule

// File: tb/tb_ip_ttl_checksum_rewrite.sv
// Directed bench for ip_ttl_checksum_rewrite: a packet-level model predicts every
// output beat and counter value; literal checks pin the model on the key cases.
module tb_ip_ttl_checksum_rewrite;

   logic         clk = 1'b0;
   logic         AXI_RESET;
   logic [255:0] S_AXIS_TDATA;
   logic [31:0]  S_AXIS_TSTRB;
   logic [127:0] S_AXIS_TUSER;
   logic         S_AXIS_TVALID;
   logic         S_AXIS_TREADY;
   logic         S_AXIS_TLAST;
   logic [31:0]  CHECKSUM_A;
   logic [31:0]  CHECKSUM_B;
   logic [255:0] M_AXIS_TDATA;
   logic [31:0]  M_AXIS_TSTRB;
   logic [127:0] M_AXIS_TUSER;
   logic         M_AXIS_TVALID;
   logic         M_AXIS_TREADY;
   logic         M_AXIS_TLAST;
   logic [31:0]  good_count;
   logic [31:0]  bad_csum_count;
   logic [31:0]  ttl_expired_count;

   always #5 clk = ~clk;

   ip_ttl_checksum_rewrite dut (
      .AXI_ACLK          (clk),
      .AXI_RESET         (AXI_RESET),
      .S_AXIS_TDATA      (S_AXIS_TDATA),
      .S_AXIS_TSTRB      (S_AXIS_TSTRB),
      .S_AXIS_TUSER      (S_AXIS_TUSER),
      .S_AXIS_TVALID     (S_AXIS_TVALID),
      .S_AXIS_TREADY     (S_AXIS_TREADY),
      .S_AXIS_TLAST      (S_AXIS_TLAST),
      .CHECKSUM_A        (CHECKSUM_A),
      .CHECKSUM_B        (CHECKSUM_B),
      .M_AXIS_TDATA      (M_AXIS_TDATA),
      .M_AXIS_TSTRB      (M_AXIS_TSTRB),
      .M_AXIS_TUSER      (M_AXIS_TUSER),
      .M_AXIS_TVALID     (M_AXIS_TVALID),
      .M_AXIS_TREADY     (M_AXIS_TREADY),
      .M_AXIS_TLAST      (M_AXIS_TLAST),
      .good_count        (good_count),
      .bad_csum_count    (bad_csum_count),
      .ttl_expired_count (ttl_expired_count)
   );

   typedef struct {
      logic [255:0] d;
      logic [31:0]  s;
      logic [127:0] u;
      logic         l;
      bit           hdr;
      int           cls;
   } beat_t;

   beat_t        exp_q[$];
   beat_t        e;
   int           errors = 0;
   int           checks = 0;
   int           m_good = 0, m_bad = 0, m_ttl = 0;
   logic [255:0] last_hdr_d;
   logic [127:0] last_hdr_u;
   int           stall_cnt = 0;
   bit           toggle = 0;

   localparam logic [127:0] USR = 128'h01234567_89ABCDEE_00000000_13579BDF;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Packet-level rules: ones-complement fold of the two sums, then header classification.
   function automatic void model_hdr(input logic [255:0] d_in, input logic [127:0] u_in,
                                     input logic [31:0] a, input logic [31:0] b,
                                     output logic [255:0] d_out, output logic [127:0] u_out,
                                     output int cls);
      longint unsigned x;
      int              y;
      bit              ok;
      x = 64'(a) + 64'(b);
      while (x > 64'hFFFF) x = (x & 64'hFFFF) + (x >> 16);
      ok    = (d_in[159:144] == 16'h0800) && (d_in[143:136] == 8'h45) && (x == 64'hFFFF);
      d_out = d_in;
      u_out = u_in;
      if (ok && d_in[79:72] > 8'd1) begin
         d_out[79:72] = d_in[79:72] - 8'd1;
         y = int'(d_in[63:48]) + 256;
         if (y > 65535) y = y - 65535;
         d_out[63:48] = y[15:0];
         cls = 0;
      end else begin
         u_out[32] = 1'b1;
         cls = ok ? 2 : 1;
      end
   endfunction

   function automatic logic [255:0] mk_hdr(input logic [15:0] et, input logic [7:0] vi,
                                           input logic [7:0] ttl, input logic [15:0] hc,
                                           input logic [31:0] seed);
      logic [255:0] h;
      for (int i = 0; i < 8; i++) h[i*32 +: 32] = seed ^ (32'h9E3779B9 * 32'(i + 1));
      h[159:144] = et;
      h[143:136] = vi;
      h[79:72]   = ttl;
      h[63:48]   = hc;
      return h;
   endfunction

   task automatic send_beat(input logic [255:0] d, input logic [31:0] s,
                            input logic [127:0] u, input logic l);
      bit hs;
      S_AXIS_TDATA  = d;
      S_AXIS_TSTRB  = s;
      S_AXIS_TUSER  = u;
      S_AXIS_TLAST  = l;
      S_AXIS_TVALID = 1'b1;
      hs = 0;
      for (int n = 0; n < 100 && !hs; n++) begin
         @(negedge clk);
         hs = S_AXIS_TREADY;
         @(posedge clk);
         #1;
      end
      S_AXIS_TVALID = 1'b0;
      chk("input_handshake", hs, 1);
   endtask

   task automatic send_pkt(input logic [255:0] hdr, input logic [31:0] a, input logic [31:0] b,
                           input int nbeats, input int nsend, input bit lat_chk);
      beat_t        x;
      logic [255:0] p;
      model_hdr(hdr, USR, a, b, x.d, x.u, x.cls);
      x.s   = '1;
      x.l   = (nbeats == 1);
      x.hdr = 1;
      exp_q.push_back(x);
      CHECKSUM_A = a;
      CHECKSUM_B = b;
      send_beat(hdr, '1, USR, nbeats == 1);
      if (lat_chk) begin
         @(negedge clk);
         chk("latency_fold_idle", M_AXIS_TVALID, 0);
         @(negedge clk);
         chk("latency_emit_valid", M_AXIS_TVALID, 1);
         chk("latency_emit_ttl", M_AXIS_TDATA[79:72], x.d[79:72]);
         @(posedge clk);
         #1;
      end
      for (int i = 1; i < nsend; i++) begin
         for (int k = 0; k < 8; k++) p[k*32 +: 32] = $urandom;
         x.d   = p;
         x.u   = USR ^ 128'(i);
         x.l   = (i == nbeats - 1);
         x.s   = x.l ? 32'hFFFF_0000 : 32'hFFFF_FFFF;
         x.hdr = 0;
         exp_q.push_back(x);
         send_beat(x.d, x.s, x.u, x.l);
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
      chk("drain_empty", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      #2;
      if (stall_cnt > 0) begin
         M_AXIS_TREADY = 1'b0;
         stall_cnt--;
      end else if (toggle) begin
         M_AXIS_TREADY = ~M_AXIS_TREADY;
      end else begin
         M_AXIS_TREADY = 1'b1;
      end
   end

   logic         prev_stall = 1'b0;
   logic [255:0] prev_d;
   logic [127:0] prev_u;
   logic         prev_l;

   always @(negedge clk) begin
      if (AXI_RESET) begin
         prev_stall = 1'b0;
      end else begin
         chk("good_count", good_count, 32'(m_good));
         chk("bad_csum_count", bad_csum_count, 32'(m_bad));
         chk("ttl_expired_count", ttl_expired_count, 32'(m_ttl));
         if (prev_stall) begin
            chk("stall_valid", M_AXIS_TVALID, 1);
            chk("stall_data", M_AXIS_TDATA, prev_d);
            chk("stall_user", M_AXIS_TUSER, prev_u);
            chk("stall_last", M_AXIS_TLAST, prev_l);
         end
         if (M_AXIS_TVALID && M_AXIS_TREADY) begin
            chk("beat_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("out_data", M_AXIS_TDATA, e.d);
               chk("out_strb", M_AXIS_TSTRB, e.s);
               chk("out_user", M_AXIS_TUSER, e.u);
               chk("out_last", M_AXIS_TLAST, e.l);
               if (e.hdr) begin
                  last_hdr_d = M_AXIS_TDATA;
                  last_hdr_u = M_AXIS_TUSER;
                  case (e.cls)
                     0:       m_good++;
                     1:       m_bad++;
                     default: m_ttl++;
                  endcase
               end
            end
         end
         prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
         prev_d     = M_AXIS_TDATA;
         prev_u     = M_AXIS_TUSER;
         prev_l     = M_AXIS_TLAST;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] h;
      logic [255:0] hx;
      AXI_RESET     = 1'b1;
      S_AXIS_TVALID = 1'b0;
      S_AXIS_TDATA  = '0;
      S_AXIS_TSTRB  = '0;
      S_AXIS_TUSER  = '0;
      S_AXIS_TLAST  = 1'b0;
      CHECKSUM_A    = '0;
      CHECKSUM_B    = '0;
      M_AXIS_TREADY = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_m_valid", M_AXIS_TVALID, 0);
      chk("rst_m_data", M_AXIS_TDATA, 0);
      chk("rst_m_user", M_AXIS_TUSER, 0);
      chk("rst_m_last", M_AXIS_TLAST, 0);
      chk("rst_counts", {good_count, bad_csum_count, ttl_expired_count}, 0);
      @(posedge clk);
      #1;
      AXI_RESET = 1'b0;
      @(negedge clk);
      chk("rst_s_ready", S_AXIS_TREADY, 1);
      @(posedge clk);
      #1;

      // Valid header, 3 beats, with latency probe
      h = mk_hdr(16'h0800, 8'h45, 8'h40, 16'hB861, 32'h1111_2222);
      send_pkt(h, 32'h0002FFFD, 32'h0, 3, 3, 1);
      drain();
      chk("t1_ttl", last_hdr_d[79:72], 8'h3F);
      chk("t1_csum", last_hdr_d[63:48], 16'hB961);
      hx = h;
      hx[79:72] = 8'h3F;
      hx[63:48] = 16'hB961;
      chk("t1_other_bytes", last_hdr_d, hx);
      chk("t1_user", last_hdr_u, USR);
      chk("t1_good", good_count, 1);

      // End-around carry on checksum rewrite
      h = mk_hdr(16'h0800, 8'h45, 8'h40, 16'hFF00, 32'h3333_4444);
      send_pkt(h, 32'h0002FFFD, 32'h0, 2, 2, 0);
      drain();
      chk("t2_csum", last_hdr_d[63:48], 16'h0001);
      chk("t2_ttl", last_hdr_d[79:72], 8'h3F);
      chk("t2_good", good_count, 2);

      // Bad checksum, wrong ethertype, wrong ver/IHL
      h = mk_hdr(16'h0800, 8'h45, 8'h40, 16'hB861, 32'h5555_6666);
      send_pkt(h, 32'h0001FFFE, 32'h1, 2, 2, 0);
      drain();
      chk("t3_data", last_hdr_d, h);
      chk("t3_bad_bit", last_hdr_u[32], 1);
      chk("t3_bad", bad_csum_count, 1);
      h = mk_hdr(16'h0806, 8'h45, 8'h40, 16'hB861, 32'h7777_8888);
      send_pkt(h, 32'h0002FFFD, 32'h0, 2, 2, 0);
      drain();
      chk("t3b_data", last_hdr_d, h);
      chk("t3b_user", last_hdr_u, USR | (128'h1 << 32));
      chk("t3b_bad", bad_csum_count, 2);
      h = mk_hdr(16'h0800, 8'h46, 8'h40, 16'hB861, 32'h9999_AAAA);
      send_pkt(h, 32'h0002FFFD, 32'h0, 1, 1, 0);
      drain();
      chk("t3c_bad", bad_csum_count, 3);

      // TTL expiry at 1 and 0
      h = mk_hdr(16'h0800, 8'h45, 8'h01, 16'hB861, 32'hBBBB_CCCC);
      send_pkt(h, 32'h0002FFFD, 32'h0, 2, 2, 0);
      drain();
      chk("t4_data", last_hdr_d, h);
      chk("t4_bad_bit", last_hdr_u[32], 1);
      chk("t4_ttl_exp", ttl_expired_count, 1);
      h = mk_hdr(16'h0800, 8'h45, 8'h00, 16'hB861, 32'hDDDD_EEEE);
      send_pkt(h, 32'h0002FFFD, 32'h0, 2, 2, 0);
      drain();
      chk("t4b_data", last_hdr_d, h);
      chk("t4b_ttl_exp", ttl_expired_count, 2);
      chk("t4b_good_unchanged", good_count, 2);

      // Single-beat packet stalled in EMIT, then a back-to-back 4-beat packet with toggling ready
      stall_cnt = 7;
      h = mk_hdr(16'h0800, 8'h45, 8'h80, 16'h1234, 32'h0F0F_0F0F);
      send_pkt(h, 32'h0002FFFD, 32'h0, 1, 1, 0);
      toggle = 1;
      h = mk_hdr(16'h0800, 8'h45, 8'h10, 16'hABCD, 32'hF0F0_F0F0);
      send_pkt(h, 32'hFFFF0000, 32'h0000FFFF, 4, 4, 0);
      drain();
      toggle = 0;
      chk("t5_ttl", last_hdr_d[79:72], 8'h0F);
      chk("t5_csum", last_hdr_d[63:48], 16'hACCD);
      chk("t5_good", good_count, 4);
      chk("t5_bad", bad_csum_count, 3);
      chk("t5_ttl_exp", ttl_expired_count, 2);
      repeat (2) @(posedge clk);
      #1;

      // Reset for one cycle while in PASS mid-packet
      h = mk_hdr(16'h0800, 8'h45, 8'h40, 16'hB861, 32'h2468_ACE0);
      send_pkt(h, 32'h0002FFFD, 32'h0, 3, 2, 0);
      AXI_RESET = 1'b1;
      @(posedge clk);
      #1;
      AXI_RESET = 1'b0;
      exp_q.delete();
      m_good = 0;
      m_bad  = 0;
      m_ttl  = 0;
      @(negedge clk);
      chk("t6_m_valid", M_AXIS_TVALID, 0);
      chk("t6_counts", {good_count, bad_csum_count, ttl_expired_count}, 0);
      chk("t6_s_ready", S_AXIS_TREADY, 1);
      @(posedge clk);
      #1;
      h = mk_hdr(16'h0800, 8'h45, 8'h22, 16'h0000, 32'h1357_2468);
      send_pkt(h, 32'h0002FFFD, 32'h0, 2, 2, 0);
      drain();
      chk("t6_ttl", last_hdr_d[79:72], 8'h21);
      chk("t6_csum", last_hdr_d[63:48], 16'h0100);
      chk("t6_good", good_count, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
